// File: rtl/mips_harvard_mem.sv
// Harvard instruction/data memory responder for mips_cpu_harvard: word-serial preload,
// combinational reads, single-cycle data writes and a sticky illegal-access monitor.
module mips_harvard_mem #(
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS = 256,
  parameter logic [31:0] DATA_BASE   = 32'h00001000,
  parameter int unsigned DATA_WORDS  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_mem,
  input  logic [31:0] init_mem_addr,
  input  logic [31:0] init_instr,
  output logic        instr_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] fault_addr,
  output logic [15:0] access_count
);

  localparam int unsigned IW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int unsigned DW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [31:0] ISPAN = 32'(4 * INSTR_WORDS);
  localparam logic [31:0] DSPAN = 32'(4 * DATA_WORDS);
  localparam logic [1:0] CODE_INSTR    = 2'd1;
  localparam logic [1:0] CODE_DATA     = 2'd2;
  localparam logic [1:0] CODE_CONFLICT = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FAULT} state_t;

  state_t state, state_next;

  logic [31:0] imem [0:INSTR_WORDS-1];
  logic [31:0] dmem [0:DATA_WORDS-1];

  logic [31:0] i_off, d_off, ni_off, nd_off;
  logic        i_ok, d_ok, ni_ok, nd_ok;
  logic [IW-1:0] i_idx, ni_idx;
  logic [DW-1:0] d_idx, nd_idx, dmem_widx;
  logic        imem_we, dmem_we, fault_set, count_inc;
  logic [31:0] dmem_wdata, fault_addr_nxt;
  logic [1:0]  fault_code_nxt;

  // Region decode: aligned and inside the region; addresses below base wrap to huge offsets.
  always_comb begin
    i_off  = instr_address - INSTR_BASE;
    d_off  = data_address - DATA_BASE;
    ni_off = init_mem_addr - INSTR_BASE;
    nd_off = init_mem_addr - DATA_BASE;
    i_ok   = (instr_address[1:0] == 2'b00) && (i_off < ISPAN);
    d_ok   = (data_address[1:0] == 2'b00) && (d_off < DSPAN);
    ni_ok  = (init_mem_addr[1:0] == 2'b00) && (ni_off < ISPAN);
    nd_ok  = (init_mem_addr[1:0] == 2'b00) && (nd_off < DSPAN);
    i_idx  = IW'(i_off >> 2);
    d_idx  = DW'(d_off >> 2);
    ni_idx = IW'(ni_off >> 2);
    nd_idx = DW'(nd_off >> 2);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (init_mem) state_next = fault_set ? FAULT : LOAD;
      LOAD:    if (init_mem) state_next = fault_set ? FAULT : LOAD;
               else          state_next = RUN;
      RUN:     if (fault_set) state_next = FAULT;
      default: state_next = FAULT;
    endcase
  end

  // Read muxing, write enables and fault detection; reset blocks any commit at its edge.
  always_comb begin
    instr_active   = 1'b0;
    instr_readdata = '0;
    data_readdata  = '0;
    imem_we        = 1'b0;
    dmem_we        = 1'b0;
    dmem_wdata     = data_writedata;
    dmem_widx      = d_idx;
    fault_set      = 1'b0;
    fault_code_nxt = 2'd0;
    fault_addr_nxt = '0;
    count_inc      = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (init_mem) begin
          if (ni_ok) begin
            imem_we = !reset;
          end else if (nd_ok) begin
            dmem_we    = !reset;
            dmem_wdata = init_instr;
            dmem_widx  = nd_idx;
          end else begin
            fault_set      = 1'b1;
            fault_code_nxt = CODE_DATA;
            fault_addr_nxt = init_mem_addr;
          end
        end
      end
      RUN: begin
        instr_active = 1'b1;
        if (i_ok) instr_readdata = imem[i_idx];
        if (data_read && d_ok) data_readdata = dmem[d_idx];
        if (data_read && data_write) begin
          fault_set      = 1'b1;
          fault_code_nxt = CODE_CONFLICT;
          fault_addr_nxt = data_address;
        end else if ((data_read || data_write) && !d_ok) begin
          fault_set      = 1'b1;
          fault_code_nxt = CODE_DATA;
          fault_addr_nxt = data_address;
        end else if (!i_ok) begin
          fault_set      = 1'b1;
          fault_code_nxt = CODE_INSTR;
          fault_addr_nxt = instr_address;
        end else begin
          count_inc = data_read || data_write;
          dmem_we   = data_write && !reset;
        end
      end
      default: ;
    endcase
  end

  // Memory arrays carry no reset so preloaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem[ni_idx] <= init_instr;
    if (dmem_we) dmem[dmem_widx] <= dmem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault        <= 1'b0;
      fault_code   <= 2'd0;
      fault_addr   <= '0;
      access_count <= '0;
    end else begin
      if (fault_set && !fault) begin
        fault      <= 1'b1;
        fault_code <= fault_code_nxt;
        fault_addr <= fault_addr_nxt;
      end
      if (count_inc && (access_count != 16'hFFFF)) access_count <= access_count + 16'd1;
    end
  end

endmodule
